// File: rtl/mult_seq_shift_add.sv
// Iterative shift-and-add unsigned multiplier, one partial product per clock.
// Define MULT_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are all zero.
module mult_seq_shift_add #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [2*WIDTH-1:0]   acc_sum;
   logic                 last_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // The add cannot overflow: a WIDTH x WIDTH product always fits in 2*WIDTH bits.
   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MULT_EARLY_EXIT_EN
   // Remaining multiplier bits after this step's shift are all zero.
   assign last_step = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == LAST_STEP);
`else
   assign last_step = (cnt_q == LAST_STEP);
`endif

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
               product_d = acc_sum;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == CALC) || (state_q == DONE);
   assign product   = product_q;

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Directed bench for mult_seq_shift_add (WIDTH=4): reset, latency, backpressure, abort, exhaustive products.
module tb_mult_seq_shift_add;

   localparam int WIDTH = 4;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   int n_cmp;
   int n_err;

   mult_seq_shift_add #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input int bv);
      int l;
      l = 1;
      for (int i = 0; i < WIDTH; i++)
         if (bv[i]) l = i + 1;
`ifdef MULT_EARLY_EXIT_EN
      return l;
`else
      return (l > 0) ? WIDTH : WIDTH;
`endif
   endfunction

   // Accept (av, bv), wait for the result, optionally stall the output, then hand it off.
   task automatic run_op(input int av, input int bv, input int stall,
                         input bit rdy_early, input bit poke);
      int lat;
      logic [WIDTH-1:0] ta;
      logic [WIDTH-1:0] tb;
      a = WIDTH'(av);
      b = WIDTH'(bv);
      in_valid  = 1'b1;
      out_ready = rdy_early;
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      ta = ~a;
      tb = ~b;
      a  = ta;
      b  = tb;
      chk("busy_calc", {31'd0, busy}, 32'd1);
      chk("in_ready_calc", {31'd0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      chk("latency", lat, exp_lat(bv));
      chk("product", {24'd0, product}, av * bv);
      if (!rdy_early) begin
         for (int s = 0; s < stall; s++) begin
            in_valid = poke;
            a = 4'd1;
            b = 4'd1;
            step();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_product", {24'd0, product}, av * bv);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      step();
      chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_hs_busy", {31'd0, busy}, 32'd0);
      chk("post_hs_product", {24'd0, product}, av * bv);
      out_ready = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 4'd5;
      b         = 4'd6;

      // Reset held with live handshake inputs
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_product", {24'd0, product}, 32'd0);
      repeat (3) step();
      chk("rst_hold_busy", {31'd0, busy}, 32'd0);
      chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_hold_product", {24'd0, product}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      step();
      chk("idle_after_rst", {31'd0, busy}, 32'd0);

      // Max operands, consumer always ready
      run_op(15, 15, 0, 1'b1, 1'b0);
      // Backpressure with ignored in_valid during DONE
      run_op(7, 9, 5, 1'b0, 1'b1);

      // Abort after two CALC edges
      a = 4'd11;
      b = 4'd13;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_product", {24'd0, product}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      run_op(3, 4, 0, 1'b1, 1'b0);

      // Early-exit vectors (4 edges each without the feature)
      run_op(13, 0, 0, 1'b1, 1'b0);
      run_op(5, 2, 1, 1'b0, 1'b0);
      run_op(15, 8, 0, 1'b1, 1'b0);
      run_op(0, 15, 2, 1'b0, 1'b0);

      // Exhaustive operand space with random stalls
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run_op(i, j, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_seq_shift_add.md
Name: mult_seq_shift_add

Overview:
- Iterative shift-and-add unsigned multiplier. It is the multiply counterpart to the iterative-subtraction divider path.
- Accepts an operand pair through a valid/ready handshake and computes one partial product per clock.
- Presents a 2*WIDTH-bit product through a valid/ready output handshake.
- Sits beside the divider in the arithmetic unit and shares its operand width.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16. The product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, registered
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; internal registers=0.
  - Asserting rst_n low mid-operation aborts immediately. No partial result is ever presented.
- Datapath registers:
  - mcand: 2*WIDTH bits, loaded with zero-extended a.
  - mplier: WIDTH bits, loaded with b.
  - acc: 2*WIDTH bits, loaded with 0.
  - cnt: enough bits to count 0..WIDTH.
- State IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: load the registers, cnt=0, go to CALC.
  - a/b are sampled only at that edge; changes afterwards are ignored.
- State CALC (in_ready=0, busy=1). One step per edge:
  - if mplier[0], acc <= acc + mcand (mod 2^(2*WIDTH); cannot overflow);
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt+1.
  - When the step taken has cnt==WIDTH-1: product <= final acc value (including this step's add), go to DONE.
- Latency:
  - The accepting edge is E0. out_valid rises after edge E0+WIDTH, i.e. exactly WIDTH edges later.
  - This holds for all operands unless the optional feature is enabled.
- State DONE:
  - out_valid=1; product held stable; in_ready=0.
  - On an edge with out_ready=1: out_valid=0 and go to IDLE. in_ready is 1 from the next cycle.
  - There is no back-to-back accept in the handshake cycle.
  - Minimum initiation interval is WIDTH+2 cycles.
- After the output handshake, product keeps its last value; only out_valid qualifies it.
- in_valid asserted while not in IDLE is ignored; the source must hold it until in_ready.
- out_ready asserted while out_valid=0 has no effect.
- Boundaries:
  - a=0 or b=0 gives product=0 with normal latency.
  - a=b=2^WIDTH-1 gives (2^WIDTH-1)^2 with no truncation.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN
- Defined:
  - CALC terminates at the first step after which the shifted mplier == 0. product <= acc from that step, go to DONE.
  - An operand b==0 still takes exactly 1 CALC step.
  - Latency = max(1, index of highest set bit of b + 1) edges. The numerical result is identical.
- Undefined:
  - Fixed WIDTH-edge latency; no mplier zero-detect logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and out_ready=1 -> in_ready=1, out_valid=0, busy=0, product=0; no state change until release.
- WIDTH=4, a=15, b=15, out_ready=1 -> out_valid rises exactly 4 edges after accept; product=225 (0xE1); in_ready=1 the cycle after the handshake.
- Backpressure: a=7, b=9, out_ready=0 for 5 cycles after out_valid -> product=63 stable, out_valid=1, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> out_valid=0 next cycle.
- Reset mid-op:
  - Start a=11, b=13; drop rst_n after 2 CALC edges -> all outputs at reset values immediately.
  - After release, a=3, b=4 -> product=12 with normal latency.
- Early exit (MULT_EARLY_EXIT_EN defined):
  - a=13, b=0 -> product=0 after 1 edge.
  - a=5, b=2 -> product=10 after 2 edges.
  - a=15, b=8 -> product=120 after 4 edges.
  - With the macro undefined, all three take 4 edges.
- Exhaustive WIDTH=4: all 256 (a, b) pairs with random out_ready stalls -> every product equals a*b; latency rule holds in both macro configurations.
